// File: rtl/fft8_sequencer_if.sv
// Sample-in / bin-out valid/ready streams of the 8-point FFT sequencer.
// slave is the sequencer side, master is the producer/consumer side.
interface fft8_sequencer_if #(
  parameter int DW = 12
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_img;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_img;
  logic          out_last;

  modport master (
    output in_valid, in_real, in_img, out_ready,
    input  in_ready, out_valid, out_real, out_img, out_last
  );

  modport slave (
    input  in_valid, in_real, in_img, out_ready,
    output in_ready, out_valid, out_real, out_img, out_last
  );
endinterface

// File: rtl/fft8_sequencer.sv
// Load / compute / unload controller and sample buffer for an 8-point radix-2 DIT FFT
// driving one external butterfly. Define FFT8_STAGE_SCALE_EN to halve every write-back.
module fft8_sequencer #(
  parameter int DW         = 12,
  parameter int BF_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  fft8_sequencer_if.slave   io,
  output logic              busy,
  output logic [DW-1:0]     bf_xm_real,
  output logic [DW-1:0]     bf_xm_img,
  output logic [DW-1:0]     bf_xn_real,
  output logic [DW-1:0]     bf_xn_img,
  output logic [2:0]        bf_index,
  input  logic [DW-1:0]     bf_ym_real,
  input  logic [DW-1:0]     bf_ym_img,
  input  logic [DW-1:0]     bf_yn_real,
  input  logic [DW-1:0]     bf_yn_img
);
  localparam int            CW      = (BF_LATENCY > 0) ? $clog2(BF_LATENCY + 1) : 1;
  localparam logic [CW-1:0] PH_LAST = CW'(BF_LATENCY);

  typedef enum logic [1:0] {LOAD, CALC, UNLOAD} state_t;
  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] k;
  } op_t;

  state_t             state, state_nxt;
  logic [2:0]         n_cnt, m_cnt;
  logic [3:0]         op_cnt, op_sel;
  logic [CW-1:0]      ph;
  logic [2:0]         wa, wb;
  logic [7:0][DW-1:0] mem_re, mem_im, mem_re_nxt, mem_im_nxt;
  logic               in_fire, out_fire, op_last, op_start;
  op_t                op_nxt;

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // op = {stage, butterfly}; addresses and twiddle of the DIT flow graph
  function automatic op_t op_map(input logic [3:0] op);
    op_t r;
    r = '0;
    case (op[3:2])
      2'd0: begin r.a = {op[1:0], 1'b0};        r.b = {op[1:0], 1'b1};        r.k = 3'd0;                  end
      2'd1: begin r.a = {op[1], 1'b0, op[0]};   r.b = {op[1], 1'b1, op[0]};   r.k = {1'b0, op[0], 1'b0};   end
      2'd2: begin r.a = {1'b0, op[1:0]};        r.b = {1'b1, op[1:0]};        r.k = {1'b0, op[1:0]};       end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] wb_val(input logic [DW-1:0] v);
`ifdef FFT8_STAGE_SCALE_EN
    return {v[DW-1], v[DW-1:1]};
`else
    return v;
`endif
  endfunction

  assign io.in_ready  = (state == LOAD) && !rst;
  assign io.out_valid = (state == UNLOAD);
  assign io.out_last  = (state == UNLOAD) && (m_cnt == 3'd7);
  assign io.out_real  = mem_re[m_cnt];
  assign io.out_img   = mem_im[m_cnt];
  assign busy         = (state == CALC);

  always_comb begin
    in_fire   = io.in_valid && (state == LOAD);
    out_fire  = io.out_ready && (state == UNLOAD);
    op_last   = (state == CALC) && (ph == PH_LAST);
    op_start  = 1'b0;
    op_sel    = op_cnt + 4'd1;
    state_nxt = state;
    case (state)
      LOAD:    if (in_fire && n_cnt == 3'd7) begin
                 state_nxt = CALC;
                 op_start  = 1'b1;
                 op_sel    = 4'd0;
               end
      CALC:    if (op_last) begin
                 if (op_cnt == 4'd11) state_nxt = UNLOAD;
                 else                 op_start  = 1'b1;
               end
      UNLOAD:  if (out_fire && m_cnt == 3'd7) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
    op_nxt = op_map(op_sel);

    // Post-write view of the buffer: the next op's operands are taken from here,
    // so they already include the result being written back this cycle.
    mem_re_nxt = mem_re;
    mem_im_nxt = mem_im;
    if (in_fire) begin
      mem_re_nxt[bitrev3(n_cnt)] = io.in_real;
      mem_im_nxt[bitrev3(n_cnt)] = io.in_img;
    end
    if (op_last) begin
      mem_re_nxt[wa] = wb_val(bf_ym_real);
      mem_im_nxt[wa] = wb_val(bf_ym_img);
      mem_re_nxt[wb] = wb_val(bf_yn_real);
      mem_im_nxt[wb] = wb_val(bf_yn_img);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      n_cnt      <= '0;
      m_cnt      <= '0;
      op_cnt     <= '0;
      ph         <= '0;
      wa         <= '0;
      wb         <= '0;
      bf_xm_real <= '0;
      bf_xm_img  <= '0;
      bf_xn_real <= '0;
      bf_xn_img  <= '0;
      bf_index   <= '0;
    end else begin
      state <= state_nxt;
      if (in_fire)  n_cnt <= n_cnt + 3'd1;
      if (out_fire) m_cnt <= m_cnt + 3'd1;
      if (op_start) begin
        op_cnt     <= op_sel;
        ph         <= '0;
        wa         <= op_nxt.a;
        wb         <= op_nxt.b;
        bf_xm_real <= mem_re_nxt[op_nxt.a];
        bf_xm_img  <= mem_im_nxt[op_nxt.a];
        bf_xn_real <= mem_re_nxt[op_nxt.b];
        bf_xn_img  <= mem_im_nxt[op_nxt.b];
        bf_index   <= op_nxt.k;
      end else if (op_last) begin
        op_cnt     <= '0;
        ph         <= '0;
        bf_xm_real <= '0;
        bf_xm_img  <= '0;
        bf_xn_real <= '0;
        bf_xn_img  <= '0;
        bf_index   <= '0;
      end else if (state == CALC) begin
        ph <= ph + CW'(1);
      end
    end
  end

  // Buffer has no reset; a reset cycle suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_re <= mem_re_nxt;
      mem_im <= mem_im_nxt;
    end
  end
endmodule

// File: doc/fft8_sequencer.md
Name: fft8_sequencer

Overview:
- Controller and sample buffer for the 8-point radix-2 DIT FFT built around the existing 12-bit butterfly (twiddle lookup plus registered complex multiply).
- Accepts 8 complex time samples on a valid/ready stream and stores them in bit-reversed order.
- Runs 3 stages × 4 butterflies through one external butterfly instance, then streams 8 frequency bins out in natural order.
- Sits between the audio framing logic and the feature-extraction stage.

Parameters:
- DW, 12, sample width per real/imag component (two's complement); must match the butterfly.
- BF_LATENCY, 1, butterfly input-to-result latency in clk cycles (≥0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept an input sample
- in_real  in  DW  input sample, real part
- in_img  in  DW  input sample, imaginary part
- out_valid  out  1  output bin valid
- out_ready  in  1  downstream accepts the output bin
- out_real  out  DW  output bin, real part
- out_img  out  DW  output bin, imaginary part
- out_last  out  1  high with bin 7
- busy  out  1  high while in CALC
- bf_xm_real, bf_xm_img  out  DW  butterfly operand m (top input)
- bf_xn_real, bf_xn_img  out  DW  butterfly operand n (twiddled input)
- bf_index  out  3  twiddle index k, selects W8^k
- bf_ym_real, bf_ym_img  in  DW  butterfly result m (xm + W·xn)
- bf_yn_real, bf_yn_img  in  DW  butterfly result n (xm − W·xn)

Behaviour:
- Clocking and reset: single clock domain, everything on the rising edge of clk. Reset is synchronous, active-high.
- Storage: internal buffer of 8 complex DW-bit words. Buffer contents are not reset.
- Reset values: state=LOAD, all counters 0, in_ready=0 during reset then 1, out_valid=0, out_last=0, busy=0, all bf_* outputs 0.
- LOAD state:
  - in_ready=1.
  - Each in_valid&&in_ready handshake writes the sample for sample number n (0..7) to buffer address bitrev3(n), then increments n.
  - On the 8th handshake: n wraps to 0, in_ready drops in the next cycle, state goes to CALC.
- CALC state (busy=1, in_ready=0, out_valid=0):
  - Loop order: stage s=0..2, then butterfly j=0..3.
  - Span h=2^s, group g=j/h, offset p=j%h.
  - Addresses: a=g·2h+p, b=a+h. Twiddle: bf_index = p·(4/h), giving {0} for s=0, {0,2} for s=1, {0,1,2,3} for s=2.
  - Each butterfly is an op of BF_LATENCY+1 cycles:
    - First cycle: bf_xm_* ← buf[a] and bf_xn_* ← buf[b] are registered, bf_index is set.
    - All bf_* outputs are held stable for the whole op.
    - Last cycle: buf[a] ← bf_ym_*, buf[b] ← bf_yn_*.
  - Ops never overlap, so the next op reads the data just written.
  - CALC lasts exactly 12·(BF_LATENCY+1) cycles, then state goes to UNLOAD.
- UNLOAD state:
  - out_valid=1, out_real/out_img=buf[m] for m=0..7 (natural order), out_last=(m==7).
  - m advances only on out_valid&&out_ready.
  - Data is held stable while out_ready=0.
  - After the bin-7 handshake: out_valid=0 next cycle, state=LOAD, in_ready=1.
- Arithmetic:
  - The butterfly owns its arithmetic and wraps modulo 2^DW.
  - The sequencer does not saturate and does not extend widths.
- Boundary conditions:
  - in_valid is ignored outside LOAD.
  - out_ready is ignored outside UNLOAD.
  - There is no overlap between frames: input for the next frame waits until UNLOAD completes.
  - rst asserted in any state, including mid-op in CALC, aborts the frame. Next cycle is LOAD with n=0 and no buffer write-back.
  - bf_y* inputs are sampled only on the last cycle of an op.
- Latency:
  - First input handshake to first out_valid = 8 + 12·(BF_LATENCY+1) cycles, given in_valid held high.
  - Default BF_LATENCY=1 gives 32 cycles.

Optional Feature:
- Macro: FFT8_STAGE_SCALE_EN.
- When defined, each write-back stores an arithmetic right shift by 1 of every component (sign-preserving, floor), giving an overall 1/8 scale that prevents wrap.
- When undefined, results are stored unmodified.
- Cycle timing is identical in both cases.

Test Plan:
- Impulse: samples (1,0),(0,0)×7, BF_LATENCY=1, out_ready=1 → all 8 bins =(1,0) without scaling; out_valid first high 32 cycles after the first handshake; out_last only on bin 7.
- DC: 8×(100,0) → bin0=(800,0), bins1–7=(0,0). With FFT8_STAGE_SCALE_EN: bin0=(100,0), others (0,0).
- Butterfly sequencing:
  - Check the (a,b,bf_index) sequence for all 12 ops: (0,1,0),(2,3,0),(4,5,0),(6,7,0),(0,2,0),(1,3,2),(4,6,0),(5,7,2),(0,4,0),(1,5,1),(2,6,2),(3,7,3).
  - Check that bf_* outputs are stable for BF_LATENCY+1 cycles per op.
- Backpressure: toggle out_ready 1,0,0,1,… during UNLOAD → each bin appears exactly once, held while stalled; in_ready stays 0 until after the bin-7 handshake.
- Input gaps: in_valid low for 3 cycles between samples 4 and 5 → same result as the gap-free DC test.
- Reset mid-CALC:
  - Assert rst at op 6 → busy=0 and in_ready=1 the next cycle.
  - A fresh impulse frame after reset produces all (1,0).
  - Reset held for 1 cycle only.
